ram4k_arbiter: RTL and testbench

- Round-robin controller that shares one ram4k instance (4096 x 8, single port) between NREQ independent requesters.
- Each requester issues read/write commands over a valid/ready handshake and receives read data on a tagged response strobe.
- Sits directly in front of ram4k, owning its we/addr/din pins and consuming its dout.
- Optional lock lets one requester hold the RAM for back-to-back accesses, bounded by LOCK_MAX to prevent starvation.

---
 rtl/ram4k_arb_pkg.sv | 25 ++
 rtl/ram4k_arbiter_if.sv | 36 +++
 rtl/ram4k_arbiter_rr_pick.sv | 39 +++
 rtl/ram4k_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram4k_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ram4k_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram4k_arb_pkg
// Purpose  : Shared constants and the read-return pipeline entry type.
// Revision : 1.0 - initial release
// ============================================================================
package ram4k_arb_pkg;

    localparam int NREQ_DEF     = 2;
    localparam int NREQ_MAX     = 4;
    localparam int AW_DEF       = 12;
    localparam int DW_DEF       = 8;
    localparam int LOCK_MAX_DEF = 8;

    // Requester ids are sized for the largest legal NREQ so the type is fixed.
    localparam int ID_W = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            is_read;
    } pipe_ent_t;

endpackage
`default_nettype wire

// File: rtl/ram4k_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram4k_arbiter_if
// Purpose  : Requester command/response bus plus the ram4k pin group.
// Revision : 1.0 - initial release
// ============================================================================
interface ram4k_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 12,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout;

    // Requesters plus the RAM model sit on the master side.
    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/ram4k_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector, one-hot grant from pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import ram4k_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  wire logic [NREQ-1:0] valid_i,
    input  wire logic [ID_W-1:0] ptr_i,
    output logic      [NREQ-1:0] gnt_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == cand) && valid_i[j]) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram4k_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram4k_arbiter
// Purpose  : Round-robin/lock arbiter sharing one ram4k among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module ram4k_arbiter
    import ram4k_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ram4k_arbiter_if.slave bus_if
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [ID_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [NREQ-1:0] lock_own_q, lock_own_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;

    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_din_q;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q;
    pipe_ent_t       pipe_q [RD_LAT+1];

    logic [NREQ-1:0] rr_gnt, gnt;
    logic [ID_W-1:0] gnt_id;
    logic            lock_win, accept, acc_we, acc_lock;
    logic [AW-1:0]   acc_addr;
    logic [DW-1:0]   acc_wdata;
    int              nxt;
    pipe_ent_t       ret;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .valid_i (bus_if.req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (rr_gnt)
    );

    // lock_own_q is one-hot, so a non-zero AND means the owner is still valid.
    always_comb begin
        lock_win  = (|(lock_own_q & bus_if.req_valid)) && (lock_cnt_q < CW'(LOCK_MAX));
        gnt       = lock_win ? lock_own_q : rr_gnt;
        accept    = |gnt;
        acc_we    = |(gnt & bus_if.req_we);
        acc_lock  = |(gnt & bus_if.req_lock);
        gnt_id    = '0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                gnt_id    = ID_W'(j);
                acc_addr  = bus_if.req_addr[j*AW +: AW];
                acc_wdata = bus_if.req_wdata[j*DW +: DW];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        nxt        = int'(gnt_id) + 1;
        if ((|lock_own_q) && !(|(lock_own_q & bus_if.req_valid))) begin
            lock_own_d = '0;
            lock_cnt_d = '0;
        end
        if (accept) begin
            rr_ptr_d = (nxt >= NREQ) ? '0 : ID_W'(nxt);
            if (acc_lock) begin
                lock_own_d = gnt;
                if (lock_own_q == gnt) begin
                    lock_cnt_d = (lock_cnt_q == CW'(LOCK_MAX)) ? lock_cnt_q
                                                               : lock_cnt_q + CW'(1);
                end else begin
                    lock_cnt_d = CW'(1);
                end
            end else begin
                lock_own_d = '0;
                lock_cnt_d = '0;
            end
        end
    end

    always_comb begin
        ret         = pipe_q[RD_LAT];
        rsp_valid_d = '0;
        for (int j = 0; j < NREQ; j++) begin
            rsp_valid_d[j] = ret.valid && ret.is_read && (ret.id == ID_W'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            lock_own_q  <= '0;
            lock_cnt_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_own_q  <= lock_own_d;
            lock_cnt_q  <= lock_cnt_d;
            ram_we_q    <= accept && acc_we;
            if (accept) begin
                ram_addr_q <= acc_addr;
                ram_din_q  <= acc_wdata;
            end
            pipe_q[0]   <= '{valid: accept, id: gnt_id, is_read: !acc_we};
            for (int k = 1; k <= RD_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (|rsp_valid_d) begin
                rsp_rdata_q <= bus_if.ram_dout;
            end
        end
    end

    assign bus_if.req_ready = gnt;
    assign bus_if.ram_we    = ram_we_q;
    assign bus_if.ram_addr  = ram_addr_q;
    assign bus_if.ram_din   = ram_din_q;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram4k_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram4k_arbiter
// Purpose  : Directed bench for ram4k_arbiter with a behavioural ram4k model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram4k_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] mem [4096];

    ram4k_arbiter_if #(.NREQ(2), .AW(12), .DW(8)) bus ();

    ram4k_arbiter #(
        .NREQ(2), .AW(12), .DW(8), .RD_LAT(1), .LOCK_MAX(8)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram4k: synchronous write, registered read (one cycle latency).
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] cont_g [4]  = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [7:0] cont_d [4]  = '{8'h7A, 8'h4A, 8'h7A, 8'h4A};
    logic [1:0] lock_g [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_lock   = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.ram_dout   = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ram_we",    32'(bus.ram_we),    32'h0);
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
        chk("rst_ram_din",   32'(bus.ram_din),   32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        chk("rst_ready",     32'(bus.req_ready), 32'h0);
        rst_n = 1'b1;

        // Single requester: write 0xA5 to 0x000, then read it back.
        cyc();
        bus.req_valid = 2'b01; bus.req_we = 2'b01;
        bus.req_addr  = {12'h000, 12'h000}; bus.req_wdata = {8'h00, 8'hA5};
        #1;
        chk("wr_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        chk("wr_ram_we",   32'(bus.ram_we),   32'h1);
        chk("wr_ram_addr", 32'(bus.ram_addr), 32'h000);
        chk("wr_ram_din",  32'(bus.ram_din),  32'hA5);
        bus.req_we = 2'b00;
        #1;
        chk("rd_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 2'b00;
        #1;
        chk("rd_ram_we",   32'(bus.ram_we),   32'h0);
        chk("rd_ram_addr", 32'(bus.ram_addr), 32'h000);
        chk("rd_rsp_early", 32'(bus.rsp_valid), 32'h0);
        cyc();
        chk("rd_rsp_early2", 32'(bus.rsp_valid), 32'h0);
        cyc();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);
        cyc();
        chk("rd_rsp_once", 32'(bus.rsp_valid), 32'h0);

        // Contention: pointer is now 1, so grants run 1,0,1,0.
        for (int k = 0; k < 7; k++) begin
            cyc();
            bus.req_valid = (k < 4) ? 2'b11 : 2'b00;
            bus.req_we    = 2'b00;
            bus.req_addr  = {12'h020, 12'h010};
            #1;
            if (k < 4) chk($sformatf("cont_grant%0d", k), 32'(bus.req_ready), 32'(cont_g[k]));
            if (k >= 3) begin
                chk($sformatf("cont_rsp_id%0d", k - 3),   32'(bus.rsp_valid), 32'(cont_g[k-3]));
                chk($sformatf("cont_rsp_data%0d", k - 3), 32'(bus.rsp_rdata), 32'(cont_d[k-3]));
            end
        end

        // Lock bound: req1 holds lock with req0 pending.
        for (int k = 0; k < 12; k++) begin
            cyc();
            bus.req_valid = 2'b11;
            bus.req_lock  = 2'b10;
            #1;
            chk($sformatf("lock_grant%0d", k), 32'(bus.req_ready), 32'(lock_g[k]));
        end
        cyc();
        bus.req_valid = 2'b00;
        bus.req_lock  = 2'b00;
        repeat (4) cyc();

        // Write-read hazard across requesters on 0xFFF.
        bus.req_valid = 2'b01; bus.req_we = 2'b01;
        bus.req_addr  = {12'h000, 12'hFFF}; bus.req_wdata = {8'h00, 8'h3C};
        #1;
        chk("haz_wr_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 2'b10; bus.req_we = 2'b00;
        bus.req_addr  = {12'hFFF, 12'h000};
        #1;
        chk("haz_rd_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        bus.req_valid = 2'b00;
        cyc();
        cyc();
        chk("haz_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("haz_rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);

        // Reset one cycle after a read accept.
        cyc();
        bus.req_valid = 2'b01; bus.req_we = 2'b00;
        bus.req_addr  = {12'h020, 12'h010};
        #1;
        chk("rst_fl_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_fl_rsp0",  32'(bus.rsp_valid), 32'h0);
        chk("rst_fl_we",    32'(bus.ram_we),    32'h0);
        chk("rst_fl_addr",  32'(bus.ram_addr),  32'h0);
        cyc();
        chk("rst_fl_rsp1",  32'(bus.rsp_valid), 32'h0);
        cyc();
        chk("rst_fl_rsp2",  32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("rst_fl_rsp3",  32'(bus.rsp_valid), 32'h0);
        cyc();
        bus.req_valid = 2'b11;
        bus.req_addr  = {12'h020, 12'h123};
        #1;
        chk("rst_fl_ptr", 32'(bus.req_ready), 32'h1);

        // Idle: issue stage holds the last address.
        cyc();
        bus.req_valid = 2'b00;
        #1;
        chk("idle_issue_we",   32'(bus.ram_we),   32'h0);
        chk("idle_issue_addr", 32'(bus.ram_addr), 32'h123);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("idle_ready%0d", k), 32'(bus.req_ready), 32'h0);
            chk($sformatf("idle_we%0d", k),    32'(bus.ram_we),    32'h0);
            chk($sformatf("idle_addr%0d", k),  32'(bus.ram_addr),  32'h123);
            if (k == 1) begin
                chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h1);
                chk("idle_rsp_rdata", 32'(bus.rsp_rdata), 32'h79);
            end else begin
                chk($sformatf("idle_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
